// File: rtl/flag_branch_unit.sv
// flag_branch_unit: execute-stage stage after the ALU.
// - Registers the ALU result for writeback.
// - Holds the {V,N,C,Z} flag register and resolves conditional branches
//   using same-cycle flag bypass.
// - Owns the program counter.
// - Holds flush high for FLUSH_CYCLES unstalled cycles after a taken branch.
module flag_branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        alu_valid,
  input  logic [31:0] alu_value,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_msb,
  input  logic        alu_overflow,
  input  logic        flag_we,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [3:0]  flags,
  output logic        br_taken,
  output logic        flush,
  output logic        wb_valid,
  output logic [31:0] wb_value
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state, state_next;
  logic [2:0] flush_cnt, flush_cnt_next;

  logic       acc;
  logic       flag_upd;
  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       cond_true;
  logic       taken;

  assign acc       = ~stall_in & (state == RUN);
  assign flag_upd  = acc & alu_valid & flag_we;
  assign alu_flags = {alu_overflow, alu_msb, alu_carry, alu_zero};
  // A flag-setting instruction in the same cycle feeds the branch directly.
  assign eff_flags = flag_upd ? alu_flags : flags;
  assign taken     = acc & br_valid & cond_true;
  assign flush     = (state == FLUSH);

  // Condition-code decode against effective flags {V,N,C,Z}
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = eff_flags[0];
      3'b010: cond_true = ~eff_flags[0];
      3'b011: cond_true = eff_flags[1];
      3'b100: cond_true = ~eff_flags[1];
      3'b101: cond_true = eff_flags[2];
      3'b110: cond_true = ~eff_flags[2] & ~eff_flags[0];
      3'b111: cond_true = eff_flags[3];
      default: cond_true = 1'b0;
    endcase
  end

  // Flush FSM next-state: load counter on a taken branch, count down unstalled cycles
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      RUN: begin
        if (taken) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (!stall_in) begin
          flush_cnt_next = flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) state_next = RUN;
        end
      end
      default: begin
        state_next     = RUN;
        flush_cnt_next = '0;
      end
    endcase
  end

  // Flush FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // PC, flag register, branch pulse and writeback registers; all frozen on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      flags    <= '0;
      br_taken <= 1'b0;
      wb_valid <= 1'b0;
      wb_value <= '0;
    end else if (!stall_in) begin
      if (taken) pc <= {br_target[31:2], 2'b00};
      else       pc <= pc + 32'd4;
      if (flag_upd) flags <= alu_flags;
      br_taken <= taken;
      wb_valid <= acc & alu_valid;
      if (acc & alu_valid) wb_value <= alu_value;
    end
  end

endmodule
